camac_cycle_sequencer: RTL and testbench
========================================

# camac_cycle_sequencer

Sequences one CAMAC dataway cycle (BUSY, S1, S2) for each ISA I/O read or write addressed to the SM2201 interface board. It sits between the ISA strobe decode and the board's dataway drivers. It holds ISA IOCHRDY low for the duration of the cycle, latches the X/Q responses, and releases the host only after the cycle completes. Phase widths are parameters counted in `clk` cycles; `clk` is the ~8.33 MHz (120 ns) board clock.

## Interface
Parameters:
- `T_SETUP`, 4: cycles from BUSY rise to S1 rise (1..15)
- `T_S1`, 2: S1 width in cycles (1..15)
- `T_GAP`, 2: cycles between S1 fall and S2 rise (1..15)
- `T_S2`, 2: S2 width in cycles (1..15)
- `T_HOLD`, 2: cycles from S2 fall to BUSY fall (1..15)

Ports:
- `clk`  in  1  board clock; all logic on rising edge
- `reset`  in  1  synchronous, active-high
- `sel`  in  1  board select from ISA address decode, active-low
- `ior_n`  in  1  ISA I/O read strobe, active-low, asynchronous to `clk`
- `iow_n`  in  1  ISA I/O write strobe, active-low, asynchronous to `clk`
- `a`  in  2  register sub-address
- `x`  in  1  CAMAC X response
- `q`  in  1  CAMAC Q response
- `rdy`  out  1  ISA IOCHRDY; 0 = wait
- `busy`  out  1  CAMAC BUSY
- `s1`  out  1  CAMAC strobe S1
- `s2`  out  1  CAMAC strobe S2
- `wr_lat`  out  1  cycle direction, 1 = write; valid while `busy`=1
- `a_lat`  out  2  sub-address latched at accept
- `x_lat`  out  1  X captured during S1
- `q_lat`  out  1  Q captured during S1
- `done`  out  1  one-cycle pulse at cycle end

## Operation
- `ior_n` and `iow_n` each pass through a 2-flop synchronizer. Synchronizer flops reset to 1. `sel` and `a` are sampled directly.
- States: IDLE, SETUP, STROBE1, GAP, STROBE2, HOLD, RELEASE. A single 4-bit phase counter loads `T_x - 1` on entry to each timed state and decrements. The state advances on the edge where the counter equals 0.
- IDLE → SETUP requires `sel`=0 and exactly one synchronized strobe low.
  - On that edge: `wr_lat` ← (sync `iow_n`==0), `a_lat` ← `a`, `busy` ← 1, `rdy` ← 0.
- Both synchronized strobes low together is a protocol error. The block stays in IDLE and issues no cycle. `rdy` stays 1.
- SETUP → STROBE1 (`s1`=1) → GAP → STROBE2 (`s2`=1) → HOLD → RELEASE.
- `x_lat` and `q_lat` load `x` and `q` on the edge that leaves STROBE1. They hold that value until the next STROBE1 exit.
- HOLD exit: `busy` ← 0, `rdy` ← 1, `done` ← 1 for one cycle.
- RELEASE: wait until both synchronized strobes are high, then go to IDLE. This prevents a second cycle from one long host strobe. No timeout applies.
- Strobe or `sel` changes after accept are ignored until RELEASE.
- `reset`=1 at any edge, including mid-cycle, forces IDLE on that edge. `s1`/`s2` drop immediately and no `done` is issued.

## Timing
- Reset values: `rdy`=1, `busy`=0, `s1`=0, `s2`=0, `wr_lat`=0, `a_lat`=0, `x_lat`=0, `q_lat`=0, `done`=0, state IDLE.
- Let strobe fall at edge E, meaning it is first sampled low by sync flop 1 at E.
  - Accept happens at E+2.
  - `rdy` returns to 1 at E+2+N, where N = T_SETUP+T_S1+T_GAP+T_S2+T_HOLD. Default N=12, so E+14.
- Default phase edges, relative to accept edge A:
  - `s1` high from A+4 to A+6
  - `s2` high from A+8 to A+10
  - `busy` high from A to A+12
- `s1` and `s2` are never high in the same cycle. `busy` is 1 whenever `s1` or `s2` is 1.
- All outputs are registered; there is no combinational path from inputs.

## Test plan
- Reset, then `sel`=0, `a`=2, `iow_n` low for 40 cycles; `x`=1, `q`=0 → `busy` set 2 cycles after strobe fall; `s1` high for cycles 4–5 after accept; `s2` high for cycles 8–9; `rdy`=0 for exactly 12 cycles; `wr_lat`=1, `a_lat`=2, `x_lat`=1, `q_lat`=0; `done` pulses once; exactly one cycle issued.
- `ior_n` low, `a`=1, `q` toggled to 1 only during S1 → `wr_lat`=0, `q_lat`=1. Then `q` drops after S1 → `q_lat` stays 1.
- `sel`=1 with strobe pulses, then both strobes low with `sel`=0 → no `busy`, `rdy` stays 1 throughout.
- `reset` asserted at accept+5 (inside S1) → next edge: `busy`=0, `s1`=0, `rdy`=1, no `done`. A fresh strobe afterwards runs a full 12-cycle cycle.
- Strobe held low through cycle end, then released and reasserted → exactly two cycles. The second accept occurs 2 cycles after the re-fall.
- Parameters all set to 1 → N=5; `s1` and `s2` are single-cycle and separated by one GAP cycle.

Source files
------------

// File: rtl/camac_cycle_sequencer.sv
// camac_cycle_sequencer: one CAMAC dataway cycle (BUSY, S1, S2) per ISA I/O access.
// Ports: clk/reset (sync, active-high); sel (active-low select), ior_n/iow_n
// (async ISA strobes), a (sub-address), x/q (CAMAC responses); rdy (IOCHRDY),
// busy/s1/s2 (dataway timing), wr_lat/a_lat/x_lat/q_lat (latched cycle info),
// done (one-cycle end pulse).
module camac_cycle_sequencer #(
  parameter int unsigned T_SETUP = 4,
  parameter int unsigned T_S1    = 2,
  parameter int unsigned T_GAP   = 2,
  parameter int unsigned T_S2    = 2,
  parameter int unsigned T_HOLD  = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sel,
  input  logic       ior_n,
  input  logic       iow_n,
  input  logic [1:0] a,
  input  logic       x,
  input  logic       q,
  output logic       rdy,
  output logic       busy,
  output logic       s1,
  output logic       s2,
  output logic       wr_lat,
  output logic [1:0] a_lat,
  output logic       x_lat,
  output logic       q_lat,
  output logic       done
);

  typedef enum logic [2:0] {
    IDLE, SETUP, STROBE1, GAP, STROBE2, HOLD, RELEASE
  } state_t;

  localparam logic [3:0] LD_SETUP = 4'(T_SETUP - 1);
  localparam logic [3:0] LD_S1    = 4'(T_S1 - 1);
  localparam logic [3:0] LD_GAP   = 4'(T_GAP - 1);
  localparam logic [3:0] LD_S2    = 4'(T_S2 - 1);
  localparam logic [3:0] LD_HOLD  = 4'(T_HOLD - 1);

  state_t     state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic       ior_m, ior_q, iow_m, iow_q;
  logic       accept, cap_xq, done_nxt, busy_nxt;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    cap_xq    = 1'b0;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        // Exactly one strobe low; both low is a protocol error and is ignored.
        if (!sel && (ior_q ^ iow_q)) begin
          accept    = 1'b1;
          state_nxt = SETUP;
          cnt_nxt   = LD_SETUP;
        end
      end
      SETUP: begin
        if (cnt == 4'd0) begin
          state_nxt = STROBE1;
          cnt_nxt   = LD_S1;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      STROBE1: begin
        if (cnt == 4'd0) begin
          state_nxt = GAP;
          cnt_nxt   = LD_GAP;
          cap_xq    = 1'b1;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      GAP: begin
        if (cnt == 4'd0) begin
          state_nxt = STROBE2;
          cnt_nxt   = LD_S2;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      STROBE2: begin
        if (cnt == 4'd0) begin
          state_nxt = HOLD;
          cnt_nxt   = LD_HOLD;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      HOLD: begin
        if (cnt == 4'd0) begin
          state_nxt = RELEASE;
          done_nxt  = 1'b1;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      RELEASE: begin
        // Wait for the host to drop its strobe so one long strobe cannot
        // start a second cycle.
        if (ior_q && iow_q) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    busy_nxt = state_nxt inside {SETUP, STROBE1, GAP, STROBE2, HOLD};
  end

  // Outputs are registered from the next-state decode so they change on the
  // same edge as the state without a combinational path to the pins.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      ior_m  <= 1'b1;
      ior_q  <= 1'b1;
      iow_m  <= 1'b1;
      iow_q  <= 1'b1;
      rdy    <= 1'b1;
      busy   <= 1'b0;
      s1     <= 1'b0;
      s2     <= 1'b0;
      wr_lat <= 1'b0;
      a_lat  <= '0;
      x_lat  <= 1'b0;
      q_lat  <= 1'b0;
      done   <= 1'b0;
    end else begin
      ior_m <= ior_n;
      ior_q <= ior_m;
      iow_m <= iow_n;
      iow_q <= iow_m;
      state <= state_nxt;
      cnt   <= cnt_nxt;
      busy  <= busy_nxt;
      rdy   <= !busy_nxt;
      s1    <= (state_nxt == STROBE1);
      s2    <= (state_nxt == STROBE2);
      done  <= done_nxt;
      if (accept) begin
        wr_lat <= !iow_q;
        a_lat  <= a;
      end
      if (cap_xq) begin
        x_lat <= x;
        q_lat <= q;
      end
    end
  end

endmodule

// File: tb/tb_camac_cycle_sequencer.sv
module tb_camac_cycle_sequencer;

  logic       clk = 1'b0;
  logic       reset, sel, ior_n, iow_n, x, q;
  logic [1:0] a;
  logic       rdy, busy, s1, s2, wr_lat, x_lat, q_lat, done;
  logic [1:0] a_lat;
  logic       f_rdy, f_busy, f_s1, f_s2, f_wr_lat, f_x_lat, f_q_lat, f_done;
  logic [1:0] f_a_lat;

  int vectors = 0;
  int errs    = 0;

  int   busy_rises = 0;
  int   done_cnt   = 0;
  int   rdy_low    = 0;
  int   viol       = 0;
  logic busy_q     = 1'b0;

  always #5 clk = ~clk;

  camac_cycle_sequencer u_dut (
    .clk(clk), .reset(reset), .sel(sel), .ior_n(ior_n), .iow_n(iow_n),
    .a(a), .x(x), .q(q), .rdy(rdy), .busy(busy), .s1(s1), .s2(s2),
    .wr_lat(wr_lat), .a_lat(a_lat), .x_lat(x_lat), .q_lat(q_lat), .done(done)
  );

  camac_cycle_sequencer #(
    .T_SETUP(1), .T_S1(1), .T_GAP(1), .T_S2(1), .T_HOLD(1)
  ) u_fast (
    .clk(clk), .reset(reset), .sel(sel), .ior_n(ior_n), .iow_n(iow_n),
    .a(a), .x(x), .q(q), .rdy(f_rdy), .busy(f_busy), .s1(f_s1), .s2(f_s2),
    .wr_lat(f_wr_lat), .a_lat(f_a_lat), .x_lat(f_x_lat), .q_lat(f_q_lat),
    .done(f_done)
  );

  always @(negedge clk) begin
    busy_q <= busy;
    if (busy && !busy_q) busy_rises <= busy_rises + 1;
    if (done) done_cnt <= done_cnt + 1;
    if (!rdy) rdy_low <= rdy_low + 1;
    if ((s1 && s2) || ((s1 || s2) && !busy) ||
        (f_s1 && f_s2) || ((f_s1 || f_s2) && !f_busy)) viol <= viol + 1;
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    int r0, d0, l0;
    reset = 1'b1; sel = 1'b1; ior_n = 1'b1; iow_n = 1'b1;
    a = 2'd0; x = 1'b0; q = 1'b0;
    tick(3);
    chk("rst_rdy",    8'(rdy),    8'd1);
    chk("rst_busy",   8'(busy),   8'd0);
    chk("rst_s1",     8'(s1),     8'd0);
    chk("rst_s2",     8'(s2),     8'd0);
    chk("rst_wr_lat", 8'(wr_lat), 8'd0);
    chk("rst_a_lat",  8'(a_lat),  8'd0);
    chk("rst_x_lat",  8'(x_lat),  8'd0);
    chk("rst_q_lat",  8'(q_lat),  8'd0);
    chk("rst_done",   8'(done),   8'd0);
    reset = 1'b0;
    tick(2);

    // Write cycle, strobe held low for 40 cycles.
    r0 = busy_rises; d0 = done_cnt; l0 = rdy_low;
    sel = 1'b0; a = 2'd2; x = 1'b1; q = 1'b0; iow_n = 1'b0;
    tick(1);
    chk("wr_busy_E",   8'(busy), 8'd0);
    tick(1);
    chk("wr_busy_E1",  8'(busy), 8'd0);
    tick(1);
    chk("wr_busy_acc", 8'(busy), 8'd1);
    chk("wr_rdy_acc",  8'(rdy),  8'd0);
    chk("wr_wr_lat",   8'(wr_lat), 8'd1);
    chk("wr_a_lat",    8'(a_lat),  8'd2);
    for (int j = 1; j <= 13; j++) begin
      tick(1);
      chk("wr_s1",   8'(s1),   8'(j >= 4 && j < 6));
      chk("wr_s2",   8'(s2),   8'(j >= 8 && j < 10));
      chk("wr_busy", 8'(busy), 8'(j < 12));
      chk("wr_rdy",  8'(rdy),  8'(j >= 12));
      chk("wr_done", 8'(done), 8'(j == 12));
    end
    chk("wr_x_lat",   8'(x_lat), 8'd1);
    chk("wr_q_lat",   8'(q_lat), 8'd0);
    chk("wr_rdy_low", 8'(rdy_low - l0), 8'd12);
    tick(25);
    chk("wr_one_cycle", 8'(busy_rises - r0), 8'd1);
    chk("wr_one_done",  8'(done_cnt - d0),   8'd1);
    iow_n = 1'b1;
    tick(4);

    // Read cycle, q high only while S1 is asserted.
    x = 1'b0; q = 1'b0; a = 2'd1; ior_n = 1'b0;
    tick(3);
    chk("rd_busy",   8'(busy),   8'd1);
    chk("rd_wr_lat", 8'(wr_lat), 8'd0);
    chk("rd_a_lat",  8'(a_lat),  8'd1);
    tick(4);
    chk("rd_s1_on",  8'(s1), 8'd1);
    q = 1'b1;
    tick(2);
    chk("rd_s1_off", 8'(s1), 8'd0);
    chk("rd_q_lat",  8'(q_lat), 8'd1);
    chk("rd_x_lat",  8'(x_lat), 8'd0);
    q = 1'b0;
    tick(6);
    chk("rd_rdy_end",  8'(rdy),   8'd1);
    chk("rd_q_hold",   8'(q_lat), 8'd1);
    ior_n = 1'b1;
    tick(4);

    // Deselected strobes, then both strobes low together.
    r0 = busy_rises; l0 = rdy_low;
    sel = 1'b1;
    iow_n = 1'b0; tick(3); iow_n = 1'b1; tick(4);
    ior_n = 1'b0; tick(3); ior_n = 1'b1; tick(4);
    sel = 1'b0;
    ior_n = 1'b0; iow_n = 1'b0; tick(5);
    chk("both_rdy", 8'(rdy), 8'd1);
    ior_n = 1'b1; iow_n = 1'b1; tick(4);
    chk("nosel_busy",  8'(busy_rises - r0), 8'd0);
    chk("nosel_rdy",   8'(rdy_low - l0),    8'd0);

    // Reset inside S1, then a fresh full cycle.
    d0 = done_cnt;
    a = 2'd3; iow_n = 1'b0;
    tick(3);
    chk("rst_mid_acc", 8'(busy), 8'd1);
    tick(5);
    chk("rst_mid_s1_pre", 8'(s1), 8'd1);
    reset = 1'b1;
    tick(1);
    chk("rst_mid_busy", 8'(busy), 8'd0);
    chk("rst_mid_s1",   8'(s1),   8'd0);
    chk("rst_mid_rdy",  8'(rdy),  8'd1);
    chk("rst_mid_done", 8'(done), 8'd0);
    reset = 1'b0; iow_n = 1'b1;
    tick(4);
    chk("rst_mid_nodone", 8'(done_cnt - d0), 8'd0);
    l0 = rdy_low;
    iow_n = 1'b0;
    tick(3);
    chk("fresh_busy", 8'(busy), 8'd1);
    tick(11);
    chk("fresh_rdy_pre", 8'(rdy), 8'd0);
    tick(1);
    chk("fresh_rdy",  8'(rdy),  8'd1);
    chk("fresh_done", 8'(done), 8'd1);
    chk("fresh_rdy_low", 8'(rdy_low - l0), 8'd12);
    iow_n = 1'b1;
    tick(4);

    // Long strobe, release, re-assert: exactly two cycles.
    r0 = busy_rises;
    iow_n = 1'b0;
    tick(3);
    chk("two_acc1", 8'(busy), 8'd1);
    tick(14);
    chk("two_hold_rel", 8'(busy), 8'd0);
    iow_n = 1'b1;
    tick(3);
    iow_n = 1'b0;
    tick(2);
    chk("two_refall_wait", 8'(busy), 8'd0);
    tick(1);
    chk("two_acc2", 8'(busy), 8'd1);
    tick(12);
    iow_n = 1'b1;
    tick(4);
    chk("two_cycles", 8'(busy_rises - r0), 8'd2);

    // All phase widths 1 on the second instance.
    iow_n = 1'b0;
    tick(3);
    chk("fast_acc", 8'(f_busy), 8'd1);
    for (int j = 1; j <= 6; j++) begin
      tick(1);
      chk("fast_s1",   8'(f_s1),   8'(j == 1));
      chk("fast_s2",   8'(f_s2),   8'(j == 3));
      chk("fast_busy", 8'(f_busy), 8'(j < 5));
      chk("fast_rdy",  8'(f_rdy),  8'(j >= 5));
      chk("fast_done", 8'(f_done), 8'(j == 5));
    end
    tick(8);
    iow_n = 1'b1;
    tick(4);
    chk("strobe_rules", 8'(viol), 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
